// File: rtl/fnd_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Segment table is active-high {g,f,e,d,c,b,a}.
package fnd_pkg;

    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h27,
        7'h7F, 7'h67, 7'h77, 7'h7C,
        7'h58, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t seg_level(
        input seg_t pat,
        input logic active_low
    );
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/fnd_hex7.sv
// Nibble to active-high 7-segment pattern.
// Purely combinational; pin polarity is applied by the caller.
module fnd_hex7
    import fnd_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_pat
);

    assign o_pat = SEG_TABLE[i_nib];

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed N-digit FND driver with PWM brightness,
// leading-zero suppression and frame-synchronous value updates.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int N_DIGITS       = 6,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1,
    parameter bit LZ_SUPPRESS    = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic [3:0]            i_bright,
    output logic [SEG_W-1:0]      o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_com,
    output logic                  o_frame,
    output logic                  o_pend
);

    localparam int PH_LEN = SCAN_DIV / 16;
    localparam int SW     = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
    localparam int DW     = $clog2(N_DIGITS);
    localparam int VW     = 4 * N_DIGITS;

    localparam logic [SW-1:0]       SUB_MAX = SW'(PH_LEN - 1);
    localparam logic [DW-1:0]       DIG_MAX = DW'(N_DIGITS - 1);
    localparam seg_t                SEG_OFF = seg_level('0, SEG_ACTIVE_LOW);
    localparam logic [N_DIGITS-1:0] COM_OFF = {N_DIGITS{COM_ACTIVE_LOW}};

    // Prescaler is kept as {phase, sub} so the PWM phase needs no divider.
    logic [SW-1:0]       sub_q, sub_d;
    logic [3:0]          phase_q, phase_d;
    logic [DW-1:0]       digit_q, digit_d;
    logic                frame_q, frame_d;
    logic                pend_q, pend_d;
    logic [VW-1:0]       pval_q, pval_d;
    logic [N_DIGITS-1:0] pdp_q, pdp_d;
    logic [N_DIGITS-1:0] pblank_q, pblank_d;
    logic [VW-1:0]       dval_q, dval_d;
    logic [N_DIGITS-1:0] ddp_q, ddp_d;
    logic [N_DIGITS-1:0] dblank_q, dblank_d;
    seg_t                seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [N_DIGITS-1:0] com_q, com_d;

    always_comb begin
        sub_d   = sub_q;
        phase_d = phase_q;
        digit_d = digit_q;
        frame_d = 1'b0;
        if (!i_en) begin
            sub_d   = '0;
            phase_d = '0;
            digit_d = '0;
        end else begin
            if (sub_q == SUB_MAX) begin
                sub_d   = '0;
                phase_d = phase_q + 4'd1;
            end else begin
                sub_d = sub_q + SW'(1);
            end
            if (phase_q == 4'hF && sub_q == SUB_MAX) begin
                frame_d = (digit_q == DIG_MAX);
                digit_d = frame_d ? '0 : digit_q + DW'(1);
            end
        end
    end

    // A load in the boundary cycle stays pending; the old one moves on.
    always_comb begin
        pend_d   = pend_q;
        pval_d   = pval_q;
        pdp_d    = pdp_q;
        pblank_d = pblank_q;
        dval_d   = dval_q;
        ddp_d    = ddp_q;
        dblank_d = dblank_q;
        if (frame_q && pend_q) begin
            dval_d   = pval_q;
            ddp_d    = pdp_q;
            dblank_d = pblank_q;
            pend_d   = 1'b0;
        end
        if (i_load) begin
            pval_d   = i_value;
            pdp_d    = i_dp;
            pblank_d = i_blank;
            pend_d   = 1'b1;
        end
    end

    logic [N_DIGITS-1:0] dark;
    logic                zero_run;

    always_comb begin
        dark     = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (dval_q[4*k +: 4] == 4'h0);
            dark[k]  = dblank_q[k] ||
                       (LZ_SUPPRESS && (k != 0) && zero_run && !ddp_q[k]);
        end
    end

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_dark;
    seg_t       cur_pat;

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (digit_q == DW'(k)) begin
                cur_nib  = dval_q[4*k +: 4];
                cur_dp   = ddp_q[k];
                cur_dark = dark[k];
            end
        end
    end

    fnd_hex7 u_hex7 (
        .i_nib (cur_nib),
        .o_pat (cur_pat)
    );

    logic                lit;
    logic                show;
    logic [N_DIGITS-1:0] com_act;

    always_comb begin
        lit     = i_en && (phase_q != 4'd0) && (phase_q <= i_bright);
        show    = i_en && !cur_dark;
        com_act = lit ? (N_DIGITS'(1) << digit_q) : '0;
        com_d   = COM_ACTIVE_LOW ? ~com_act : com_act;
        seg_d   = seg_level(show ? cur_pat : '0, SEG_ACTIVE_LOW);
        dp_d    = (show && cur_dp) ^ SEG_ACTIVE_LOW;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sub_q    <= '0;
            phase_q  <= '0;
            digit_q  <= '0;
            frame_q  <= 1'b0;
            pend_q   <= 1'b0;
            pval_q   <= '0;
            pdp_q    <= '0;
            pblank_q <= '0;
            dval_q   <= '0;
            ddp_q    <= '0;
            dblank_q <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= SEG_ACTIVE_LOW;
            com_q    <= COM_OFF;
        end else begin
            sub_q    <= sub_d;
            phase_q  <= phase_d;
            digit_q  <= digit_d;
            frame_q  <= frame_d;
            pend_q   <= pend_d;
            pval_q   <= pval_d;
            pdp_q    <= pdp_d;
            pblank_q <= pblank_d;
            dval_q   <= dval_d;
            ddp_q    <= ddp_d;
            dblank_q <= dblank_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            com_q    <= com_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_com   = com_q;
    assign o_frame = frame_q;
    assign o_pend  = pend_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: 4 digits, 32-clock slots,
// active-low pins, leading-zero suppression on.
module tb_fnd_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic        i_load;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic [3:0]  i_blank;
    logic [3:0]  i_bright;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_com;
    logic        o_frame;
    logic        o_pend;

    int errors = 0;
    int checks = 0;

    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    int         exp_cnt;

    fnd_scan_driver #(
        .N_DIGITS (4),
        .SCAN_DIV (32)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (i_en),
        .i_load   (i_load),
        .i_value  (i_value),
        .i_dp     (i_dp),
        .i_blank  (i_blank),
        .i_bright (i_bright),
        .o_seg    (o_seg),
        .o_dp     (o_dp),
        .o_com    (o_com),
        .o_frame  (o_frame),
        .o_pend   (o_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] v,
                        input logic [3:0] dp,
                        input logic [3:0] bl);
        i_value = v;
        i_dp    = dp;
        i_blank = bl;
        i_load  = 1'b1;
        step();
        i_load  = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!o_frame && n < 300) begin
            step();
            n++;
        end
        check("frame_seen", {31'd0, o_frame}, 32'd1);
    endtask

    task automatic set_exp(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3,
                           input logic [3:0] dp_n, input int cnt);
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        for (int k = 0; k < 4; k++) exp_dp[k] = dp_n[k];
        exp_cnt = cnt;
    endtask

    // Called with the counter at digit 0, phase 0 (sample holds s=0).
    task automatic measure(input string tag);
        int         cnt [4];
        logic [6:0] seg_s [4];
        logic       dp_s [4];
        int         dead_bad;
        int         other_bad;
        logic [3:0] want_com;
        int         s, d, p;
        dead_bad  = 0;
        other_bad = 0;
        for (int k = 0; k < 4; k++) begin
            cnt[k]   = 0;
            seg_s[k] = 'x;
            dp_s[k]  = 1'bx;
        end
        for (int i = 1; i <= 128; i++) begin
            step();
            i_load = 1'b0;
            s = i - 1;
            d = s / 32;
            p = s % 32;
            want_com = 4'hF & ~(4'b0001 << d);
            if (o_com === want_com) cnt[d]++;
            else if (o_com !== 4'hF) other_bad++;
            if (p < 2 && o_com !== 4'hF) dead_bad++;
            if (p == 10) begin
                seg_s[d] = o_seg;
                dp_s[d]  = o_dp;
            end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_seg%0d", tag, k), {25'd0, seg_s[k]},
                  {25'd0, exp_seg[k]});
            check($sformatf("%s_dp%0d", tag, k), {31'd0, dp_s[k]},
                  {31'd0, exp_dp[k]});
            check($sformatf("%s_on%0d", tag, k), cnt[k], exp_cnt);
        end
        check({tag, "_dead"}, dead_bad, 0);
        check({tag, "_stray_com"}, other_bad, 0);
        check({tag, "_frame_end"}, {31'd0, o_frame}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        i_en     = 1'b0;
        i_load   = 1'b0;
        i_value  = '0;
        i_dp     = '0;
        i_blank  = '0;
        i_bright = 4'd15;
        step();
        step();
        check("rst_seg", {25'd0, o_seg}, 32'h7F);
        check("rst_dp", {31'd0, o_dp}, 32'd1);
        check("rst_com", {28'd0, o_com}, 32'hF);
        check("rst_frame", {31'd0, o_frame}, 32'd0);
        check("rst_pend", {31'd0, o_pend}, 32'd0);
        rst_n = 1'b1;
        step();

        load(16'h1234, 4'h0, 4'h0);
        check("pend_after_load", {31'd0, o_pend}, 32'd1);
        i_en = 1'b1;
        wait_frame();
        check("pend_at_frame", {31'd0, o_pend}, 32'd1);
        set_exp(7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 30);
        measure("b15");
        check("pend_cleared", {31'd0, o_pend}, 32'd0);

        i_bright = 4'd7;
        set_exp(7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 14);
        measure("b7");

        i_bright = 4'd0;
        set_exp(7'h19, 7'h30, 7'h24, 7'h79, 4'hF, 0);
        measure("b0");

        i_bright = 4'd15;
        step();
        load(16'h0050, 4'h0, 4'h0);
        wait_frame();
        set_exp(7'h40, 7'h12, 7'h7F, 7'h7F, 4'hF, 30);
        measure("lz");

        step();
        load(16'h0050, 4'b0100, 4'b0010);
        wait_frame();
        set_exp(7'h40, 7'h7F, 7'h40, 7'h7F, 4'b1011, 30);
        measure("lzdp");

        step();
        load(16'hAAAA, 4'h0, 4'h0);
        wait_frame();
        i_value = 16'hBBBB;
        i_dp    = 4'h0;
        i_blank = 4'h0;
        i_load  = 1'b1;
        set_exp(7'h08, 7'h08, 7'h08, 7'h08, 4'hF, 30);
        measure("coinc_old");
        check("coinc_pend", {31'd0, o_pend}, 32'd1);
        set_exp(7'h03, 7'h03, 7'h03, 7'h03, 4'hF, 30);
        measure("coinc_new");
        check("coinc_pend_clr", {31'd0, o_pend}, 32'd0);

        repeat (5) step();
        i_en = 1'b0;
        step();
        check("dis_com", {28'd0, o_com}, 32'hF);
        check("dis_frame", {31'd0, o_frame}, 32'd0);
        check("dis_seg", {25'd0, o_seg}, 32'h7F);
        load(16'h000C, 4'h0, 4'h0);
        check("dis_pend", {31'd0, o_pend}, 32'd1);
        repeat (3) step();
        i_en = 1'b1;
        set_exp(7'h03, 7'h03, 7'h03, 7'h03, 4'hF, 30);
        measure("restart");
        check("restart_pend", {31'd0, o_pend}, 32'd1);
        set_exp(7'h27, 7'h7F, 7'h7F, 7'h7F, 4'hF, 30);
        measure("restart_new");
        check("restart_pend_clr", {31'd0, o_pend}, 32'd0);

        load(16'h9999, 4'hF, 4'h0);
        check("pre_rst_pend", {31'd0, o_pend}, 32'd1);
        repeat (40) step();
        rst_n = 1'b0;
        #2;
        check("arst_seg", {25'd0, o_seg}, 32'h7F);
        check("arst_dp", {31'd0, o_dp}, 32'd1);
        check("arst_com", {28'd0, o_com}, 32'hF);
        check("arst_pend", {31'd0, o_pend}, 32'd0);
        step();
        rst_n = 1'b1;
        set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF, 30);
        measure("post_rst");
        check("post_rst_pend", {31'd0, o_pend}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
